// File: rtl/pipe_divider_pkg.sv
// rtl/pipe_divider_pkg.sv - shared op-mode enum and result flag positions for pipe_divider
package pipe_divider_pkg;

  typedef enum logic {
    DIV_UNSIGNED = 1'b0,
    DIV_SIGNED   = 1'b1
  } div_mode_e;

  localparam int FLAG_DBZ = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_W   = 2;

endpackage

// File: rtl/divider_stage.sv
// rtl/divider_stage.sv - one registered restoring-division step, frozen while hold is high
module divider_stage
  import pipe_divider_pkg::*;
#(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8,
  parameter int IDX      = 1,
  parameter int SW       = 3 * DIVISOR + DIVIDEND + 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  input  logic [SW-1:0] prev,
  output logic [SW-1:0] next
);

  typedef struct packed {
    logic                valid;
    div_mode_e           mode;
    logic                neg_q;
    logic                neg_r;
    logic                dbz;
    logic                ovf;
    logic [DIVISOR:0]    r;
    logic [DIVIDEND-1:0] q;
    logic [DIVISOR-1:0]  d;
    logic [DIVISOR-1:0]  raw;
  } stage_t;

  // q starts as the dividend magnitude; bit BIT is consumed here and replaced by its quotient bit
  localparam int BIT = DIVIDEND - IDX;

  stage_t             cur;
  stage_t             upd;
  stage_t             held;
  logic [DIVISOR+1:0] shifted;
  logic [DIVISOR+1:0] trial;

  always_comb begin
    cur     = prev;
    upd     = cur;
    shifted = {cur.r, cur.q[BIT]};
    trial   = shifted - {2'b00, cur.d};
    if (trial[DIVISOR+1]) begin
      upd.r      = shifted[DIVISOR:0];
      upd.q[BIT] = 1'b0;
    end else begin
      upd.r      = trial[DIVISOR:0];
      upd.q[BIT] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held <= '0;
    end else if (!hold) begin
      held <= upd;
    end
  end

  assign next = held;

endmodule

// File: rtl/pipe_divider.sv
// rtl/pipe_divider.sv - pipelined restoring divider: capture stage, DIVIDEND step stages, result register
module pipe_divider
  import pipe_divider_pkg::*;
#(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder,
  output logic                dbz,
  output logic                ovf
);

  typedef struct packed {
    logic                valid;
    div_mode_e           mode;
    logic                neg_q;
    logic                neg_r;
    logic                dbz;
    logic                ovf;
    logic [DIVISOR:0]    r;
    logic [DIVIDEND-1:0] q;
    logic [DIVISOR-1:0]  d;
    logic [DIVISOR-1:0]  raw;
  } stage_t;

  localparam int SW = $bits(stage_t);
  localparam logic [DIVIDEND-1:0] MOST_NEG = {1'b1, {(DIVIDEND-1){1'b0}}};

  logic adv;
  logic hold;
  logic sgn_a;
  logic sgn_b;

  stage_t          cap;
  stage_t          cap_reg;
  logic [SW-1:0]   links [0:DIVIDEND];
  stage_t          last;

  logic [DIVIDEND-1:0] fin_q;
  logic [DIVISOR-1:0]  fin_r;
  logic [FLAG_W-1:0]   fin_flags;

  logic                res_valid;
  logic [DIVIDEND-1:0] res_q;
  logic [DIVISOR-1:0]  res_r;
  logic [FLAG_W-1:0]   res_flags;
  logic                unused_fields;

  // Global stall: the whole pipe, bubbles included, moves only when the result slot can drain
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign hold     = !adv;

  always_comb begin
    cap   = '0;
    sgn_a = in_signed && dividend[DIVIDEND-1];
    sgn_b = in_signed && divisor[DIVISOR-1];
    if (in_valid) begin
      cap.valid = 1'b1;
      cap.mode  = in_signed ? DIV_SIGNED : DIV_UNSIGNED;
      cap.neg_q = sgn_a ^ sgn_b;
      cap.neg_r = sgn_a;
      cap.dbz   = (divisor == '0);
      cap.ovf   = in_signed && (dividend == MOST_NEG) && (&divisor);
      cap.q     = sgn_a ? -dividend : dividend;
      cap.d     = sgn_b ? -divisor : divisor;
      cap.raw   = dividend[DIVISOR-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_reg <= '0;
    end else if (adv) begin
      cap_reg <= cap;
    end
  end

  assign links[0] = cap_reg;

  for (genvar g = 1; g <= DIVIDEND; g++) begin : g_stage
    divider_stage #(
      .DIVIDEND(DIVIDEND),
      .DIVISOR (DIVISOR),
      .IDX     (g),
      .SW      (SW)
    ) u_stage (
      .clock(clock),
      .reset(reset),
      .hold (hold),
      .prev (links[g-1]),
      .next (links[g])
    );
  end

  assign last = links[DIVIDEND];
  // The divisor magnitude and the always-zero top remainder bit are not needed once stepping is done
  assign unused_fields = ^{last.d, last.r[DIVISOR]};

  always_comb begin
    fin_q     = last.q;
    fin_r     = last.r[DIVISOR-1:0];
    fin_flags = '0;
    if (last.dbz) begin
      fin_q               = '1;
      fin_r               = last.raw;
      fin_flags[FLAG_DBZ] = 1'b1;
    end else begin
      if (last.mode == DIV_SIGNED && last.neg_q) begin
        fin_q = -last.q;
      end
      if (last.mode == DIV_SIGNED && last.neg_r) begin
        fin_r = -last.r[DIVISOR-1:0];
      end
      fin_flags[FLAG_OVF] = last.ovf;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      res_r     <= '0;
      res_flags <= '0;
    end else if (adv) begin
      res_valid <= last.valid;
      res_q     <= fin_q;
      res_r     <= fin_r;
      res_flags <= fin_flags;
    end
  end

  assign out_valid = res_valid;
  assign quotient  = res_q;
  assign remainder = res_r;
  assign dbz       = res_flags[FLAG_DBZ];
  assign ovf       = res_flags[FLAG_OVF];

endmodule

// File: tb/tb_pipe_divider.sv
// tb/tb_pipe_divider.sv - randomized and directed self-checking bench for pipe_divider
module tb_pipe_divider;

  localparam int W = 16;
  localparam int D = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [D-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [D-1:0] remainder;
  logic         dbz;
  logic         ovf;

  always #5 clock = ~clock;

  pipe_divider #(.DIVIDEND(W), .DIVISOR(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz),
    .ovf      (ovf)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [D-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t exp_q [$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pushed      = 0;
  int   popped      = 0;

  function automatic res_t model(input logic sgn, input logic [W-1:0] a, input logic [D-1:0] b);
    res_t m;
    int   ai, bi, qi, ri;
    m = '0;
    if (b == '0) begin
      m.q   = '1;
      m.r   = a[D-1:0];
      m.dbz = 1'b1;
    end else begin
      if (sgn) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'(a);
        bi = int'(b);
      end
      qi    = ai / bi;
      ri    = ai % bi;
      m.q   = qi[W-1:0];
      m.r   = ri[D-1:0];
      m.ovf = sgn && (ai == -(1 << (W-1))) && (bi == -1);
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      check("reset_out_valid", 64'(out_valid), 64'd0);
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          check("result", 64'({quotient, remainder, dbz, ovf}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_signed, dividend, divisor));
        pushed++;
      end
    end
  end

  // Issue one operation into an empty pipe, then pin latency and value to hand-computed literals
  task automatic run_one(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [D-1:0] b, input res_t want);
    int   n;
    res_t got;
    check({name, "_model"}, 64'(model(sgn, a, b)), 64'(want));
    in_valid  = 1'b1;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd17);
    got = {quotient, remainder, dbz, ovf};
    check({name, "_value"}, 64'(got), 64'(want));
    @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0] ops_a [40];
    logic [D-1:0] ops_b [40];
    logic         ops_s [40];
    int           i, c, n, p0, q0;
    logic         took;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_one("u_1000_7", 1'b0, 16'd1000, 8'd7, {16'd142, 8'd6, 1'b0, 1'b0});
    run_one("s_m1000_7", 1'b1, 16'hFC18, 8'h07, {16'hFF72, 8'hFA, 1'b0, 1'b0});
    run_one("u_dbz", 1'b0, 16'h04D2, 8'h00, {16'hFFFF, 8'hD2, 1'b1, 1'b0});
    run_one("s_dbz", 1'b1, 16'h8001, 8'h00, {16'hFFFF, 8'h01, 1'b1, 1'b0});
    run_one("s_ovf", 1'b1, 16'h8000, 8'hFF, {16'h8000, 8'h00, 1'b0, 1'b1});
    run_one("s_7_m2", 1'b1, 16'd7, 8'hFE, {16'hFFFD, 8'h01, 1'b0, 1'b0});
    run_one("u_ffff_ff", 1'b0, 16'hFFFF, 8'hFF, {16'h0101, 8'h00, 1'b0, 1'b0});

    for (int k = 0; k < 40; k++) begin
      ops_s[k] = 1'($urandom_range(0, 1));
      ops_a[k] = 16'($urandom);
      ops_b[k] = 8'($urandom);
      if (k % 5 == 1) ops_b[k] = 8'($urandom_range(1, 3));
      if (k % 7 == 3) ops_b[k] = 8'h00;
      if (k % 11 == 5) begin
        ops_s[k] = 1'b1;
        ops_a[k] = 16'h8000;
        ops_b[k] = 8'hFF;
      end
    end

    p0 = pushed;
    q0 = popped;
    i  = 0;
    c  = 0;
    while (i < 40 && c < 200) begin
      out_ready = !(c >= 25 && c < 30);
      in_valid  = 1'b1;
      in_signed = ops_s[i];
      dividend  = ops_a[i];
      divisor   = ops_b[i];
      #3;
      took = in_ready;
      if (c >= 25 && c < 30) check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1;
      if (took) i++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("stall_issued", 64'(pushed - p0), 64'd40);
    check("stall_returned", 64'(popped - q0), 64'd40);

    for (int k = 0; k < 20; k++) begin
      in_valid  = 1'b1;
      in_signed = 1'($urandom_range(0, 1));
      dividend  = 16'($urandom);
      divisor   = 8'($urandom_range(1, 255));
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    #2;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_quotient", 64'(quotient), 64'd0);
    check("mid_rst_remainder", 64'(remainder), 64'd0);
    check("mid_rst_flags", 64'({dbz, ovf}), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_one("post_reset", 1'b1, 16'hFC18, 8'h07, {16'hFF72, 8'hFA, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
